signed_hex_display: RTL and testbench
=====================================

Name: signed_hex_display

Overview:
- Downstream consumer of the 8-bit sign/magnitude stage.
- Captures its 8-bit result, sign flag and overflow flag.
- Time-multiplexes them onto the board's 4-digit common-anode seven-segment display.
- Layout: digit3 shows '-' when negative, digit2 is blank, digits1:0 show the value in hex, and the decimal point of digit0 flags overflow.

Parameters:
- REFRESH_CYCLES, 100000: clk cycles each digit stays lit (1 ms at 100 MHz); must be >= 2.
- BLANK_LZ, 1: when 1, digit1 is blanked if the upper nibble is 0.

Ports:
- clk  input  1  system clock (100 MHz board clock)
- reset  input  1  synchronous, active-high reset
- load  input  1  capture strobe; samples mag/neg/ovfl on this rising edge
- mag  input  8  value from the sign/magnitude stage
- neg  input  1  sign flag; 1 = display '-'
- ovfl  input  1  overflow flag from the upstream stage
- an  output  4  digit anodes, active-low, one-hot-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values:
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Captured value, sign and ovfl all 0.
  - Refresh counter 0, digit index 0.
- Capture register:
  - On a clk edge with load=1 and reset=0, store mag, neg and ovfl.
  - Otherwise hold. load is level-sampled, so holding load high re-captures every cycle.
- Refresh counter:
  - Counts 0..REFRESH_CYCLES-1, then wraps to 0.
  - tick=1 on the cycle the counter equals REFRESH_CYCLES-1.
- Digit index FSM, states D0->D1->D2->D3->D0:
  - Advances on tick only.
  - The 2-bit index wraps from 3 to 0 with no idle state.
- Digit content, from the current index and the captured register:
  - D0: hex(mag[3:0]); dp=0 if ovfl, else dp=1.
  - D1: hex(mag[7:4]). Blank if BLANK_LZ=1 and mag[7:4]==0. dp=1.
  - D2: blank, dp=1.
  - D3: '-' (7'b0111111) if neg, else blank. dp=1.
- Output registers:
  - an, seg and dp are registered every cycle from (index, captured register).
  - an = ~(4'b0001 << index).
- Latency:
  - Outputs reflect the index and captured register with one clk of delay.
  - A load at edge t is visible on seg at edge t+1 if its digit is currently selected. Otherwise it appears when that digit is next scanned.
- Simultaneous load and tick: both take effect on the same edge. The next output register update uses the new index with the new data.
- Reset mid-scan: all state returns to reset values on the next edge, and the display goes dark for one cycle. Scanning restarts at D0 with the counter at 0.
- Hex encoding (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111

Decomposition:
- Shared package holds:
  - Segment constants: SEG_BLANK, SEG_MINUS and the 16-entry hex table.
  - The anode one-hot-low encoding.
  - The DIGIT_IDX width (2).
- One natural sub-module: hex_to_seg7, a combinational 4-bit nibble to 7-bit active-low segment decoder, instantiated once on the muxed nibble.

Test Plan (REFRESH_CYCLES=4, BLANK_LZ=1):
- Reset held for 3 cycles -> an=1111, seg=1111111, dp=1 on the first post-reset edge. The counter then reaches D1 after 4 cycles, with an=1101 one cycle after the tick.
- load with mag=0x35, neg=1, ovfl=0, then run 16 cycles -> an=1110/seg=0010010 ('5'), an=1101/seg=0110000 ('3'), an=1011/seg=1111111, an=0111/seg=0111111 ('-'). Each digit lasts 4 cycles and dp=1 throughout.
- load with mag=0x0A, neg=0, ovfl=1 -> D0 seg=0001000 with dp=0, D1 blank (leading zero), D3 blank.
- load asserted on the same edge as a tick into D1, with mag=0xF0 -> the next cycle shows an=1101, seg=0001110 ('F'). The old value never appears on D1.
- reset asserted while on D2 mid-count -> the next edge gives all outputs at their reset values, then the scan restarts at D0 with captured value 0 shown as seg=1000000.
- mag=0x80, neg=1, ovfl=1 (the -128 case) -> D0 '0' with dp=0, D1 '8' (0000000), D3 '-'.

Source files
------------

// File: rtl/signed_hex_display_pkg.sv
// Shared constants for the signed hex display: active-low segment patterns,
// anode encoding and the digit-scan state type.
package signed_hex_display_pkg;

   localparam int DIGIT_IDX_W = 2;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Active-low {g,f,e,d,c,b,a} patterns indexed by nibble value 0..F
   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic [DIGIT_IDX_W-1:0] {
      D0 = 2'd0,
      D1 = 2'd1,
      D2 = 2'd2,
      D3 = 2'd3
   } digit_t;

   function automatic logic [3:0] anode_sel(input digit_t d);
      return ~(4'b0001 << d);
   endfunction

endpackage

// File: rtl/signed_hex_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
   import signed_hex_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/signed_hex_display.sv
// Captures a sign/magnitude result and scans it across a 4-digit
// common-anode display: '-' on digit3, hex value on digits1:0, dp0 = overflow.
module signed_hex_display
   import signed_hex_display_pkg::*;
#(
   parameter int REFRESH_CYCLES = 100000,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] mag,
   input  logic       neg,
   input  logic       ovfl,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CNT_W = $clog2(REFRESH_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

   logic [CNT_W-1:0] refresh_cnt;
   logic             tick;
   digit_t           digit;
   logic [7:0]       cap_mag;
   logic             cap_neg;
   logic             cap_ovfl;
   logic [3:0]       nibble;
   logic [6:0]       hex_seg;
   logic [6:0]       seg_next;
   logic             dp_next;

   assign tick = (refresh_cnt == CNT_LAST);

   // load is level-sampled, so a held strobe keeps refreshing the capture
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_mag  <= 8'd0;
         cap_neg  <= 1'b0;
         cap_ovfl <= 1'b0;
      end else if (load) begin
         cap_mag  <= mag;
         cap_neg  <= neg;
         cap_ovfl <= ovfl;
      end
   end

   assign nibble = (digit == D1) ? cap_mag[7:4] : cap_mag[3:0];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg    (hex_seg)
   );

   always_comb begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
      unique case (digit)
         D0: begin
            seg_next = hex_seg;
            dp_next  = ~cap_ovfl;
         end
         D1: seg_next = (BLANK_LZ && (cap_mag[7:4] == 4'd0)) ? SEG_BLANK : hex_seg;
         D2: seg_next = SEG_BLANK;
         D3: seg_next = cap_neg ? SEG_MINUS : SEG_BLANK;
         default: seg_next = SEG_BLANK;
      endcase
   end

   // Outputs come from the current index, so they trail the scan state by one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit       <= D0;
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
         dp          <= 1'b1;
      end else begin
         if (tick) begin
            refresh_cnt <= '0;
            unique case (digit)
               D0: digit <= D1;
               D1: digit <= D2;
               D2: digit <= D3;
               D3: digit <= D0;
               default: digit <= D0;
            endcase
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
         an  <= anode_sel(digit);
         seg <= seg_next;
         dp  <= dp_next;
      end
   end

endmodule

// File: tb/tb_signed_hex_display.sv
// Scoreboard bench for signed_hex_display with a 4-cycle refresh period:
// each stimulus cycle queues the hand-computed display state expected after it.
module tb_signed_hex_display;

   localparam logic [6:0] S_BLANK = 7'b1111111;
   localparam logic [6:0] S_MINUS = 7'b0111111;
   localparam logic [6:0] S_0     = 7'b1000000;
   localparam logic [6:0] S_3     = 7'b0110000;
   localparam logic [6:0] S_5     = 7'b0010010;
   localparam logic [6:0] S_8     = 7'b0000000;
   localparam logic [6:0] S_A     = 7'b0001000;
   localparam logic [6:0] S_F     = 7'b0001110;

   typedef struct packed {
      logic        care;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic [15:0] id;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [7:0] mag;
   logic       neg;
   logic       ovfl;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int   testsRun    = 0;
   int   testsFailed = 0;
   int   stepId      = 0;
   exp_t expQ[$];
   exp_t monEntry;

   always #5 clk = ~clk;

   signed_hex_display #(
      .REFRESH_CYCLES (4),
      .BLANK_LZ       (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .mag   (mag),
      .neg   (neg),
      .ovfl  (ovfl),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   // One call per clock: drive inputs on the falling edge, queue the expected outputs
   task automatic applyStimulus(input logic r, input logic l, input logic [7:0] m,
                                input logic n, input logic o, input logic c,
                                input logic [3:0] ea, input logic [6:0] es, input logic ed);
      exp_t e;
      @(negedge clk);
      reset = r;
      load  = l;
      mag   = m;
      neg   = n;
      ovfl  = o;
      stepId++;
      e.care = c;
      e.an   = ea;
      e.seg  = es;
      e.dp   = ed;
      e.id   = 16'(stepId);
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      testsRun++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
         testsFailed++;
         $display("[TB] FAIL step%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                  e.id, an, seg, dp, e.an, e.seg, e.dp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         monEntry = expQ.pop_front();
         if (monEntry.care) checkOutput(monEntry);
      end
   end

   task automatic hold(input int cycles, input logic [3:0] ea, input logic [6:0] es, input logic ed);
      repeat (cycles) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ea, es, ed);
   endtask

   task automatic doReset();
      repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b1111, S_BLANK, 1'b1);
   endtask

   // Reset, load on the first free edge, then walk one full scan plus the wrap to D0
   task automatic scanAfterReset(input logic [7:0] m, input logic n, input logic o,
                                 input logic [6:0] s0, input logic d0,
                                 input logic [6:0] s1, input logic [6:0] s3);
      doReset();
      applyStimulus(1'b0, 1'b1, m, n, o, 1'b1, 4'b1110, S_0, 1'b1);
      hold(3, 4'b1110, s0, d0);
      hold(4, 4'b1101, s1, 1'b1);
      hold(4, 4'b1011, S_BLANK, 1'b1);
      hold(4, 4'b0111, s3, 1'b1);
      hold(1, 4'b1110, s0, d0);
   endtask

   initial begin
      reset = 1'b1;
      load  = 1'b0;
      mag   = 8'h00;
      neg   = 1'b0;
      ovfl  = 1'b0;

      scanAfterReset(8'h35, 1'b1, 1'b0, S_5, 1'b1, S_3, S_MINUS);
      scanAfterReset(8'h0A, 1'b0, 1'b1, S_A, 1'b0, S_BLANK, S_BLANK);
      scanAfterReset(8'h80, 1'b1, 1'b1, S_0, 1'b0, S_8, S_MINUS);

      // Load coinciding with the tick into D1: the new value is shown straight away
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 4'b1110, S_0, 1'b1);
      hold(2, 4'b1110, S_0, 1'b1);
      applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 4'b1110, S_0, 1'b1);
      hold(4, 4'b1101, S_F, 1'b1);
      hold(4, 4'b1011, S_BLANK, 1'b1);
      hold(4, 4'b0111, S_BLANK, 1'b1);
      hold(1, 4'b1110, S_0, 1'b1);

      // Reset while D2 is partway through its slot
      doReset();
      applyStimulus(1'b0, 1'b1, 8'h35, 1'b1, 1'b1, 1'b1, 4'b1110, S_0, 1'b1);
      hold(3, 4'b1110, S_5, 1'b0);
      hold(4, 4'b1101, S_3, 1'b1);
      hold(1, 4'b1011, S_BLANK, 1'b1);
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'b1111, S_BLANK, 1'b1);
      hold(4, 4'b1110, S_0, 1'b1);
      hold(1, 4'b1101, S_BLANK, 1'b1);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      if (expQ.size() > 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
